// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_pkg
// Description : Shared types and default sizing for the DMA engine slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

    localparam int c_ADDR_WIDTH = 32;
    localparam int c_DATA_WIDTH = 32;
    localparam int c_FIFO_DEPTH = 4;
    localparam int c_WORD_BYTES = 4;
    localparam int c_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width that can hold any occupancy value 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_if
// Description : Memory-side read-request/response and write ports of the DMA.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_if
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) ();

    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_resp_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output rd_req_valid, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_req_ready, rd_resp_valid, rd_data, wr_ready
    );

    modport slave (
        input  rd_req_valid, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_req_ready, rd_resp_valid, rd_data, wr_ready
    );

endinterface
`default_nettype wire

// File: rtl/dma_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dma_fifo
// Description : Synchronous FIFO buffering read data until it is written out.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_fifo
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = c_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [DATA_WIDTH-1:0]          push_data,
    input  logic                           pop,
    output logic [DATA_WIDTH-1:0]          pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [credit_width(DEPTH)-1:0] count
);

    localparam int CW = credit_width(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == c_LAST) ? '0 : p + PW'(1);
    endfunction

    // A pop frees the head slot in the same cycle, so push-at-full is legal with it.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != c_FULL) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == c_FULL);
    assign empty    = (r_count == '0);
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : dma_engine
// Description : Single-channel word-copy DMA with credit-limited read issue.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_engine
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dma_start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [15:0]           length,
    output logic                  dma_done,
    output logic                  busy,
    dma_if.master                 mem
);

    localparam int CW = credit_width(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  c_STEP  = ADDR_WIDTH'(c_WORD_BYTES);
    localparam logic [CW:0]            c_LIMIT = (CW + 1)'(FIFO_DEPTH);
    localparam logic [c_CNT_WIDTH-1:0] c_ONE   = c_CNT_WIDTH'(1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [c_CNT_WIDTH-1:0]  r_reads_left;
    logic [c_CNT_WIDTH-1:0]  r_writes_left;
    logic [CW-1:0]           r_outstanding;

    logic [CW-1:0]           w_fifo_count;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [DATA_WIDTH-1:0]   w_fifo_head;

    logic                    w_run;
    logic                    w_in_done;
    logic                    w_in_busy;
    logic                    w_start;
    logic                    w_credit_ok;
    logic                    w_rd_req_valid;
    logic                    w_rd_accept;
    logic                    w_resp_accept;
    logic                    w_wr_valid;
    logic                    w_wr_accept;
    logic                    w_last_write;

    assign w_start = (r_state == IDLE) && dma_start;

    // Every issued read owns a FIFO slot until written, so the FIFO never overflows.
    assign w_credit_ok    = !w_fifo_full &&
                            (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < c_LIMIT);
    assign w_rd_req_valid = w_run && (r_reads_left != '0) && w_credit_ok;
    assign w_rd_accept    = w_rd_req_valid && mem.rd_req_ready;
    assign w_resp_accept  = mem.rd_resp_valid && (r_outstanding != '0);
    assign w_wr_valid     = w_run && !w_fifo_empty;
    assign w_wr_accept    = w_wr_valid && mem.wr_ready;
    assign w_last_write   = w_wr_accept && (r_writes_left == c_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        w_in_done    = 1'b0;
        w_in_busy    = 1'b1;
        unique case (r_state)
            IDLE: begin
                w_in_busy = 1'b0;
                if (dma_start) begin
                    w_state_next = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (w_last_write) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_in_done    = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr     <= '0;
            r_wr_addr     <= '0;
            r_reads_left  <= '0;
            r_writes_left <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_start) begin
                r_rd_addr     <= src_addr;
                r_wr_addr     <= dst_addr;
                r_reads_left  <= length;
                r_writes_left <= length;
            end else begin
                if (w_rd_accept) begin
                    r_rd_addr    <= r_rd_addr + c_STEP;
                    r_reads_left <= r_reads_left - c_ONE;
                end
                if (w_wr_accept) begin
                    r_wr_addr     <= r_wr_addr + c_STEP;
                    r_writes_left <= r_writes_left - c_ONE;
                end
            end
            unique case ({w_rd_accept, w_resp_accept})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: ;
            endcase
        end
    end

    dma_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_resp_accept),
        .push_data (mem.rd_data),
        .pop       (w_wr_accept),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Outputs are forced quiet while rst is high, not just from the cycle after.
    assign mem.rd_req_valid = !rst && w_rd_req_valid;
    assign mem.rd_addr      = rst ? '0 : r_rd_addr;
    assign mem.wr_valid     = !rst && w_wr_valid;
    assign mem.wr_addr      = rst ? '0 : r_wr_addr;
    assign mem.wr_data      = w_fifo_head;
    assign dma_done         = !rst && w_in_done;
    assign busy             = !rst && w_in_busy;

endmodule
`default_nettype wire

// File: tb/tb_dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_engine
// Description : Directed scoreboard bench for dma_engine with a latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_engine;

    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
    logic        dma_done;
    logic        busy;

    dma_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem ();

    dma_engine #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dma_start (dma_start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .dma_done  (dma_done),
        .busy      (busy),
        .mem       (mem)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_exp_t;
    typedef struct { int due; logic [31:0] data; } resp_t;

    wr_exp_t     exp_q[$];
    resp_t       resp_q[$];
    int          nchk, nerr, cyc;
    int          rd_count, wr_count, done_count, rd_vseen, wr_vseen;
    int          wr_idx, skip_to, latency;
    int          xfer_rd_base, xfer_wr_base;
    int          first_rd_edge, last_rd_edge, first_wr_edge, last_wr_edge;
    logic [31:0] exp_rd_addr;
    bit          rnd_ready;
    bit          prev_wr_stall, prev_rd_stall;
    logic [31:0] prev_wr_data, prev_wr_addr, prev_rd_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the values the DUT will see at the coming rising edge.
    task automatic sample();
        if (dma_done) done_count++;
        if (mem.rd_req_valid) rd_vseen++;
        if (mem.wr_valid) wr_vseen++;
        if (prev_rd_stall && !rst && mem.rd_req_valid)
            check("rd_hold_addr", mem.rd_addr, prev_rd_addr);
        if (prev_wr_stall && !rst) begin
            check("wr_hold_valid", mem.wr_valid, 1);
            check("wr_hold_data", mem.wr_data, prev_wr_data);
            check("wr_hold_addr", mem.wr_addr, prev_wr_addr);
        end
        if (mem.rd_req_valid && mem.rd_req_ready) begin
            check("rd_addr", mem.rd_addr, exp_rd_addr);
            check("rd_credit", ((rd_count - xfer_rd_base) - (wr_count - xfer_wr_base)) < c_DEPTH, 1);
            if (rd_count == xfer_rd_base) first_rd_edge = cyc + 1;
            last_rd_edge = cyc + 1;
            exp_rd_addr  = exp_rd_addr + 32'd4;
            resp_q.push_back('{due: cyc + 1 + latency, data: mem_word(mem.rd_addr)});
            rd_count++;
        end
        if (mem.wr_valid && mem.wr_ready) begin
            if (wr_idx < skip_to) wr_idx = skip_to;
            check("wr_expected", wr_idx < exp_q.size(), 1);
            if (wr_idx < exp_q.size()) begin
                check("wr_addr", mem.wr_addr, exp_q[wr_idx].addr);
                check("wr_data", mem.wr_data, exp_q[wr_idx].data);
            end
            if (wr_count == xfer_wr_base) first_wr_edge = cyc + 1;
            last_wr_edge = cyc + 1;
            wr_idx++;
            wr_count++;
        end
        prev_wr_stall = mem.wr_valid && !mem.wr_ready;
        prev_wr_data  = mem.wr_data;
        prev_wr_addr  = mem.wr_addr;
        prev_rd_stall = mem.rd_req_valid && !mem.rd_req_ready;
        prev_rd_addr  = mem.rd_addr;
    endtask

    // One clock: sample, cross the edge, then drive memory-side inputs at the falling edge.
    task automatic tick();
        #1;
        sample();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (resp_q.size() != 0 && resp_q[0].due == cyc + 1) begin
            mem.rd_resp_valid = 1'b1;
            mem.rd_data       = resp_q[0].data;
            void'(resp_q.pop_front());
        end else begin
            mem.rd_resp_valid = 1'b0;
            mem.rd_data       = '0;
        end
        if (rnd_ready) begin
            mem.rd_req_ready = 1'($urandom_range(0, 1));
            mem.wr_ready     = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d,
                              input logic [15:0] n, input int lat);
        latency      = lat;
        xfer_rd_base = rd_count;
        xfer_wr_base = wr_count;
        exp_rd_addr  = s;
        for (int i = 0; i < int'(n); i++)
            exp_q.push_back('{addr: d + 32'(4 * i), data: mem_word(s + 32'(4 * i))});
        src_addr  = s;
        dst_addr  = d;
        length    = n;
        dma_start = 1'b1;
        tick();
        dma_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        int n;
        base = done_count;
        n    = 0;
        while (done_count == base && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done_count != base, 1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, dma_done, 0);
        check({tag, "_rd_valid"}, mem.rd_req_valid, 0);
        check({tag, "_wr_valid"}, mem.wr_valid, 0);
        check({tag, "_rd_addr"}, mem.rd_addr, 0);
        check({tag, "_wr_addr"}, mem.wr_addr, 0);
    endtask

    initial begin
        int d0, vr0, vw0, n, rd_at_rst;
        rst = 1'b1; dma_start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        mem.rd_req_ready = 1'b1; mem.wr_ready = 1'b1;
        mem.rd_resp_valid = 1'b0; mem.rd_data = '0;
        latency = 1; rnd_ready = 1'b0;

        tick(); tick();
        check_quiet("rst");
        rst = 1'b0;
        tick();
        check_quiet("post_rst");

        // Zero length: straight to DONE, no memory traffic.
        d0 = done_count; vr0 = rd_vseen; vw0 = wr_vseen;
        start_xfer(32'h40, 32'h80, 16'd0, 1);
        check("zl_done_pulse", dma_done, 1);
        check("zl_busy", busy, 1);
        tick();
        check("zl_done_low", dma_done, 0);
        check("zl_idle", busy, 0);
        repeat (3) tick();
        check("zl_done_count", done_count - d0, 1);
        check("zl_no_rd_valid", rd_vseen - vr0, 0);
        check("zl_no_wr_valid", wr_vseen - vw0, 0);

        // Single word, memory latency 2.
        d0 = done_count;
        start_xfer(32'h100, 32'h200, 16'd1, 2);
        check("sw_first_rd_valid", mem.rd_req_valid, 1);
        check("sw_first_rd_addr", mem.rd_addr, 32'h100);
        wait_done("sw", 50);
        repeat (3) tick();
        check("sw_reads", rd_count - xfer_rd_base, 1);
        check("sw_writes", wr_count - xfer_wr_base, 1);
        check("sw_done_count", done_count - d0, 1);

        // Streaming at full rate.
        d0 = done_count;
        start_xfer(32'h100, 32'h200, 16'd8, 1);
        wait_done("st", 60);
        check("st_reads", rd_count - xfer_rd_base, 8);
        check("st_writes", wr_count - xfer_wr_base, 8);
        check("st_rd_back_to_back", last_rd_edge - first_rd_edge, 7);
        check("st_wr_back_to_back", last_wr_edge - first_wr_edge, 7);
        check("st_done_count", done_count - d0, 1);

        // Write backpressure: the credit limit stops reads at the FIFO depth.
        d0 = done_count;
        mem.wr_ready = 1'b0;
        start_xfer(32'h1000, 32'h3000, 16'd8, 1);
        repeat (20) tick();
        check("bp_reads_capped", rd_count - xfer_rd_base, c_DEPTH);
        check("bp_rd_valid_low", mem.rd_req_valid, 0);
        check("bp_no_writes", wr_count - xfer_wr_base, 0);
        mem.wr_ready = 1'b1;
        wait_done("bp", 80);
        check("bp_reads", rd_count - xfer_rd_base, 8);
        check("bp_writes", wr_count - xfer_wr_base, 8);
        check("bp_done_count", done_count - d0, 1);

        // Address wrap at the top of the address space.
        start_xfer(32'hFFFF_FFF8, 32'hFFFF_FFFC, 16'd4, 1);
        wait_done("wrap", 60);
        check("wrap_writes", wr_count - xfer_wr_base, 4);

        // Start while busy, with random ready on both ports.
        d0 = done_count;
        rnd_ready = 1'b1;
        start_xfer(32'h400, 32'h800, 16'd8, 2);
        repeat (3) tick();
        src_addr = 32'h1_0000; dst_addr = 32'h2_0000; length = 16'd3; dma_start = 1'b1;
        tick();
        dma_start = 1'b0;
        wait_done("sb", 400);
        rnd_ready = 1'b0;
        mem.rd_req_ready = 1'b1; mem.wr_ready = 1'b1;
        repeat (6) tick();
        check("sb_reads", rd_count - xfer_rd_base, 8);
        check("sb_writes", wr_count - xfer_wr_base, 8);
        check("sb_done_count", done_count - d0, 1);

        // Reset after 3 of 8 words, then a fresh transfer.
        start_xfer(32'h500, 32'hA00, 16'd8, 2);
        n = 0;
        while ((wr_count - xfer_wr_base) < 3 && n < 60) begin
            tick();
            n++;
        end
        check("rm_three_writes", wr_count - xfer_wr_base, 3);
        d0 = done_count;
        rst = 1'b1;
        rd_at_rst = rd_count;
        skip_to = exp_q.size();
        #1;
        check_quiet("rm_under_rst");
        tick();
        rst = 1'b0;
        check_quiet("rm_after_rst");
        repeat (10) tick();
        check("rm_no_done", done_count - d0, 0);
        check("rm_no_more_writes", wr_count - xfer_wr_base, 3);
        check("rm_no_more_reads", rd_count - rd_at_rst, 0);
        d0 = done_count;
        start_xfer(32'h300, 32'h600, 16'd4, 1);
        wait_done("rm_restart", 60);
        check("rm_restart_writes", wr_count - xfer_wr_base, 4);
        check("rm_restart_done_count", done_count - d0, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
